adc_touch_responder: RTL and testbench

Synthesizable model of the ADS7843-style touch-screen ADC: the responder end of the serial link that the touch controller drives. It samples DCLK, CS_n and DIN in the system clock domain, decodes 8-bit control bytes, and drives BUSY, DOUT (12-bit conversion result from programmable X/Y sources) and PENIRQ_n. It is used in benches and in loop-back builds in place of the physical ADC.

---
 rtl/adc_touch_pkg.sv | 39 +++
 rtl/adc_edge_sync.sv | 36 +++
 rtl/adc_touch_responder.sv | 182 ++++++++++++++++++
 tb/tb_adc_touch_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/adc_touch_pkg.sv
// Shared types and constants for the ADS7843-style touch ADC responder.
// Holds the FSM states, the default channel codes and the control-byte field positions.
package adc_touch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT,
    ST_DATA
  } state_e;

  localparam logic [2:0] X_CHAN_DEF = 3'b101;
  localparam logic [2:0] Y_CHAN_DEF = 3'b001;

  // Control byte layout, MSB first on the wire: S,A2,A1,A0,MODE,SER/DFR,PD1,PD0
  localparam int unsigned CMD_S_BIT    = 7;
  localparam int unsigned CMD_A_HI     = 6;
  localparam int unsigned CMD_A_LO     = 4;
  localparam int unsigned CMD_MODE_BIT = 3;
  localparam int unsigned CMD_SER_BIT  = 2;
  localparam int unsigned CMD_PD_HI    = 1;
  localparam int unsigned CMD_PD_LO    = 0;

  // Picks the conversion source by channel code; 8-bit mode zeroes the low nibble.
  function automatic logic [11:0] snapshot(input logic [2:0]  chan,
                                           input logic        mode8,
                                           input logic [11:0] x_val,
                                           input logic [11:0] y_val,
                                           input logic [2:0]  x_code,
                                           input logic [2:0]  y_code);
    logic [11:0] v;
    if (chan == x_code)      v = x_val;
    else if (chan == y_code) v = y_val;
    else                     v = '0;
    if (mode8) v[3:0] = '0;
    return v;
  endfunction

endpackage

// File: rtl/adc_edge_sync.sv
// Multi-stage synchronizer with registered rise/fall pulse outputs.
// Pulses appear STAGES+1 clocks after the raw input changes.
module adc_edge_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/adc_touch_responder.sv
// Responder side of an ADS7843-style touch ADC serial link: decodes control
// bytes on DCLK rises and returns a 12-bit result on DCLK falls.
module adc_touch_responder
  import adc_touch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [2:0]  X_CHAN      = X_CHAN_DEF,
  parameter logic [2:0]  Y_CHAN      = Y_CHAN_DEF
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iADC_DCLK,
  input  logic        iADC_CS_n,
  input  logic        iADC_DIN,
  output logic        oADC_DOUT,
  output logic        oADC_BUSY,
  output logic        oADC_PENIRQ_n,
  input  logic [11:0] iX_VALUE,
  input  logic [11:0] iY_VALUE,
  input  logic        iTOUCH,
  output logic [7:0]  oCMD,
  output logic        oCMD_VALID
);

  logic dclk_rise;
  logic dclk_fall;

  adc_edge_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_dclk_sync (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .d_i    (iADC_DCLK),
    .rise_o (dclk_rise),
    .fall_o (dclk_fall)
  );

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   cs_n_s;
  logic                   din_s;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cs_sync_q  <= '1;
      din_sync_q <= '0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], iADC_CS_n};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], iADC_DIN};
    end
  end

  assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];

  state_e      state_q,  state_d;
  logic [3:0]  cnt_q,    cnt_d;
  logic [6:0]  sh_q,     sh_d;
  logic [11:0] res_q,    res_d;
  logic [7:0]  cmd_q,    cmd_d;
  logic        valid_q,  valid_d;
  logic        busy_q,   busy_d;
  logic        dout_q,   dout_d;
  logic [1:0]  pd_q,     pd_d;
  logic        penirq_q, penirq_d;
  logic [7:0]  new_cmd;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      res_q    <= '0;
      cmd_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dout_q   <= 1'b0;
      pd_q     <= '0;
      penirq_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      res_q    <= res_d;
      cmd_q    <= cmd_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      dout_q   <= dout_d;
      pd_q     <= pd_d;
      penirq_q <= penirq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    res_d   = res_q;
    cmd_d   = cmd_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    dout_d  = dout_q;
    pd_d    = pd_q;
    new_cmd = {sh_q, din_s};

    // Pen interrupt is only reported while idle or hunting for a start bit, with power-down bits 00.
    penirq_d = ((pd_q == 2'b00) && ((state_q == ST_IDLE) || (state_q == ST_CMD)))
               ? ~iTOUCH : 1'b1;

    // Deselect overrides any DCLK edge seen in the same cycle.
    if (cs_n_s) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sh_d    = '0;
      busy_d  = 1'b0;
      dout_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = '0;
          sh_d    = '0;
        end
        ST_CMD: begin
          // With the counter at 0, only a 1 (start bit) begins a byte.
          if (dclk_rise && ((cnt_q != 4'd0) || din_s)) begin
            sh_d = new_cmd[6:0];
            if (cnt_q == 4'd7) begin
              cmd_d   = new_cmd;
              valid_d = 1'b1;
              res_d   = snapshot(new_cmd[CMD_A_HI:CMD_A_LO], new_cmd[CMD_MODE_BIT],
                                 iX_VALUE, iY_VALUE, X_CHAN, Y_CHAN);
              pd_d    = new_cmd[CMD_PD_HI:CMD_PD_LO];
              cnt_d   = '0;
              state_d = ST_WAIT;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ST_WAIT: begin
          if (dclk_fall) begin
            if (cnt_q == 4'd0) begin
              busy_d = 1'b1;
              dout_d = 1'b0;
              cnt_d  = 4'd1;
            end else begin
              busy_d  = 1'b0;
              dout_d  = res_q[11];
              res_d   = {res_q[10:0], 1'b0};
              cnt_d   = '0;
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (dclk_fall) begin
            if (cnt_q == 4'd11) begin
              dout_d  = 1'b0;
              cnt_d   = '0;
              sh_d    = '0;
              state_d = ST_CMD;
            end else begin
              dout_d = res_q[11];
              res_d  = {res_q[10:0], 1'b0};
              cnt_d  = cnt_q + 4'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign oADC_DOUT     = dout_q;
  assign oADC_BUSY     = busy_q;
  assign oADC_PENIRQ_n = penirq_q;
  assign oCMD          = cmd_q;
  assign oCMD_VALID    = valid_q;

endmodule

// File: tb/tb_adc_touch_responder.sv
// Directed self-checking bench for adc_touch_responder.
module tb_adc_touch_responder;

  localparam int unsigned H = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        dclk;
  logic        cs_n;
  logic        din;
  logic        dout;
  logic        busy;
  logic        penirq_n;
  logic [11:0] xv;
  logic [11:0] yv;
  logic        touch;
  logic [7:0]  cmd;
  logic        cmd_valid;

  int compared   = 0;
  int mismatched = 0;
  int vcount     = 0;

  always #5 clk = ~clk;

  adc_touch_responder #(
    .SYNC_STAGES (2),
    .X_CHAN      (3'b101),
    .Y_CHAN      (3'b001)
  ) dut (
    .iCLK          (clk),
    .iRST          (rst),
    .iADC_DCLK     (dclk),
    .iADC_CS_n     (cs_n),
    .iADC_DIN      (din),
    .oADC_DOUT     (dout),
    .oADC_BUSY     (busy),
    .oADC_PENIRQ_n (penirq_n),
    .iX_VALUE      (xv),
    .iY_VALUE      (yv),
    .iTOUCH        (touch),
    .oCMD          (cmd),
    .oCMD_VALID    (cmd_valid)
  );

  always @(posedge clk) if (cmd_valid === 1'b1) vcount++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dclk_cycle(input logic b);
    din  = b;
    dclk = 1'b1;
    tick(H);
    dclk = 1'b0;
    tick(H);
  endtask

  task automatic send_cmd(input logic [7:0] c, input int lead_zeros);
    int vc0;
    vc0 = vcount;
    for (int i = 0; i < lead_zeros; i++) dclk_cycle(1'b0);
    for (int i = 7; i >= 0; i--) dclk_cycle(c[i]);
    check("busy_on", {15'd0, busy}, 16'd1);
    check("dout_busy", {15'd0, dout}, 16'd0);
    check("cmd", {8'd0, cmd}, {8'd0, c});
    check("cmd_valid_cnt", vcount[15:0], vc0[15:0] + 16'd1);
    check("penirq_wait", {15'd0, penirq_n}, 16'd1);
  endtask

  task automatic frame(input logic [7:0] c, input logic [11:0] v, input int lead_zeros);
    send_cmd(c, lead_zeros);
    for (int i = 11; i >= 0; i--) begin
      dclk_cycle(1'b0);
      check($sformatf("dout_D%0d", i), {15'd0, dout}, {15'd0, v[i]});
      if (i == 11) check("busy_off", {15'd0, busy}, 16'd0);
      if (i == 6)  check("penirq_data", {15'd0, penirq_n}, 16'd1);
    end
    dclk_cycle(1'b0);
    check("dout_tail", {15'd0, dout}, 16'd0);
    check("busy_tail", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    #1ms;
    $error("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; dclk = 1'b0; cs_n = 1'b1; din = 1'b0;
    touch = 1'b1; xv = '0; yv = '0;
    tick(3);
    check("rst_dout", {15'd0, dout}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_penirq", {15'd0, penirq_n}, 16'd1);
    check("rst_cmd", {8'd0, cmd}, 16'h0000);
    check("rst_valid", {15'd0, cmd_valid}, 16'd0);
    rst = 1'b0;
    tick(2);
    check("penirq_after_rst", {15'd0, penirq_n}, 16'd0);

    // X read, full 12 bits
    cs_n = 1'b0;
    tick(4);
    check("penirq_cmd", {15'd0, penirq_n}, 16'd0);
    xv = 12'hA5C;
    frame(8'hD0, 12'hA5C, 0);
    check("penirq_after_frame", {15'd0, penirq_n}, 16'd0);

    // Y read in 8-bit mode
    yv = 12'h3F7;
    frame(8'h98, 12'h3F0, 0);

    // Leading zeros then an unmapped channel
    frame(8'hA0, 12'h000, 3);

    // Power-down bits 11 mask the pen interrupt
    frame(8'hD3, 12'hA5C, 0);
    check("penirq_pd11", {15'd0, penirq_n}, 16'd1);
    touch = 1'b0; tick(3);
    check("penirq_pd11_notouch", {15'd0, penirq_n}, 16'd1);
    touch = 1'b1;
    frame(8'hD0, 12'hA5C, 0);
    check("penirq_pd00", {15'd0, penirq_n}, 16'd0);
    touch = 1'b0; tick(3);
    check("penirq_release", {15'd0, penirq_n}, 16'd1);
    touch = 1'b1; tick(3);

    // Abort after D5 of an X read
    xv = 12'hFFF;
    send_cmd(8'hD0, 0);
    for (int i = 11; i >= 5; i--) dclk_cycle(1'b0);
    check("dout_D5_pre_abort", {15'd0, dout}, 16'd1);
    cs_n = 1'b1;
    tick(4);
    check("abort_dout", {15'd0, dout}, 16'd0);
    check("abort_busy", {15'd0, busy}, 16'd0);
    tick(4);
    check("abort_idle_penirq", {15'd0, penirq_n}, 16'd0);
    check("abort_cmd_kept", {8'd0, cmd}, 16'h00D0);

    // Abort while busy
    cs_n = 1'b0; tick(4);
    send_cmd(8'hD0, 0);
    cs_n = 1'b1;
    tick(4);
    check("abort_wait_busy", {15'd0, busy}, 16'd0);

    // Normal frame after aborts
    cs_n = 1'b0; tick(4);
    xv = 12'h5A3;
    frame(8'hD0, 12'h5A3, 0);
    cs_n = 1'b1; tick(6);
    check("final_dout", {15'd0, dout}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
